// File: rtl/decode_stage_pkg.sv
// RV32I decode definitions: opcodes, immediate formats, field positions and the
// control-field decoder shared by the decode stage and its immediate generator.
package decode_stage_pkg;

  localparam int XLEN = 32;

  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  typedef enum logic {ST_EMPTY, ST_FULL} dec_state_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rd_we;
    logic       illegal;
  } dec_ctrl_t;

  // Unknown opcodes (including any with bits [1:0] != 2'b11) map to IMM_NONE.
  function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
    imm_fmt_e f;
    case (opc)
      OP_LUI, OP_AUIPC:                              f = IMM_U;
      OP_JAL:                                        f = IMM_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_MISC_MEM, OP_SYSTEM: f = IMM_I;
      OP_BRANCH:                                     f = IMM_B;
      OP_STORE:                                      f = IMM_S;
      default:                                       f = IMM_NONE;
    endcase
    return f;
  endfunction

  function automatic logic is_legal(input logic [6:0] opc);
    logic l;
    case (opc)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
      OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM: l = 1'b1;
      default:                              l = 1'b0;
    endcase
    return l;
  endfunction

  function automatic dec_ctrl_t decode_ctrl(input logic [31:0] w);
    dec_ctrl_t c;
    c.opcode  = w[6:0];
    c.rd      = w[RD_LSB  +: 5];
    c.funct3  = w[F3_LSB  +: 3];
    c.rs1     = w[RS1_LSB +: 5];
    c.rs2     = w[RS2_LSB +: 5];
    c.funct7  = w[F7_LSB  +: 7];
    c.illegal = !is_legal(w[6:0]);
    c.rd_we   = !c.illegal && (c.rd != 5'd0) &&
                !(w[6:0] inside {OP_BRANCH, OP_STORE, OP_MISC_MEM});
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake and decoded-instruction bundle toward execute.
// slave = decode stage view; master = fetch/execute environment view.
interface decode_stage_if
  import decode_stage_pkg::*;
#(
  parameter int data_width = XLEN
);
  logic [data_width-1:0] instr_reg_fetch;
  logic [data_width-1:0] pc_fetch;
  logic [data_width-1:0] npc_fetch;
  logic                  fetch_valid;
  logic                  fetch_ready;
  logic                  flush;
  logic                  ex_ready;
  logic                  dec_valid;
  logic [data_width-1:0] dec_instr;
  logic [data_width-1:0] dec_pc;
  logic [data_width-1:0] dec_npc;
  logic [data_width-1:0] dec_imm;
  logic [4:0]            dec_rs1;
  logic [4:0]            dec_rs2;
  logic [4:0]            dec_rd;
  logic [6:0]            dec_opcode;
  logic [2:0]            dec_funct3;
  logic [6:0]            dec_funct7;
  logic                  dec_rd_we;
  logic                  dec_illegal;

  modport slave (
    input  instr_reg_fetch, pc_fetch, npc_fetch, fetch_valid, flush, ex_ready,
    output fetch_ready, dec_valid, dec_instr, dec_pc, dec_npc, dec_imm,
           dec_rs1, dec_rs2, dec_rd, dec_opcode, dec_funct3, dec_funct7,
           dec_rd_we, dec_illegal
  );

  modport master (
    output instr_reg_fetch, pc_fetch, npc_fetch, fetch_valid, flush, ex_ready,
    input  fetch_ready, dec_valid, dec_instr, dec_pc, dec_npc, dec_imm,
           dec_rs1, dec_rs2, dec_rd, dec_opcode, dec_funct3, dec_funct7,
           dec_rd_we, dec_illegal
  );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator; R-type and unknown opcodes yield zero.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
#(
  parameter int data_width = XLEN
) (
  input  logic [31:0]           instr,
  output logic [data_width-1:0] imm
);
  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_fmt(instr[6:0]))
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = data_width'(imm32);
endmodule

// File: rtl/decode_stage.sv
// IF/ID receiver: accepts fetch words over valid/ready, registers decoded RV32I fields.
// Build option DECODE_SKID_BUFFER_EN: one-entry skid buffer, registered fetch_ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int data_width = XLEN
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave dif
);
  dec_state_e            state;
  logic                  accept, dec_free, load;
  logic [data_width-1:0] src_instr, src_pc, src_npc, src_imm;
  dec_ctrl_t             src_ctrl;
  logic [data_width-1:0] instr_q, pc_q, npc_q, imm_q;
  dec_ctrl_t             ctrl_q;

  // Output register can take a new word when empty or when execute drains it.
  assign dec_free = (state == ST_EMPTY) || dif.ex_ready;
  assign accept   = dif.fetch_valid && dif.fetch_ready;

`ifdef DECODE_SKID_BUFFER_EN
  logic                  skid_full, fetch_ready_q;
  logic [data_width-1:0] skid_instr, skid_pc, skid_npc;

  assign dif.fetch_ready = fetch_ready_q;
  assign src_instr = skid_full ? skid_instr : dif.instr_reg_fetch;
  assign src_pc    = skid_full ? skid_pc    : dif.pc_fetch;
  assign src_npc   = skid_full ? skid_npc   : dif.npc_fetch;
  // A full skid has priority; fetch_ready is low then, so no new word competes.
  assign load      = skid_full ? dec_free : (accept && dec_free);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_full     <= 1'b0;
      fetch_ready_q <= 1'b1;
      skid_instr    <= '0;
      skid_pc       <= '0;
      skid_npc      <= '0;
    end else if (dif.flush) begin
      skid_full     <= 1'b0;
      fetch_ready_q <= 1'b1;
    end else if (skid_full) begin
      if (dec_free) begin
        skid_full     <= 1'b0;
        fetch_ready_q <= 1'b1;
      end
    end else if (accept && !dec_free) begin
      skid_full     <= 1'b1;
      fetch_ready_q <= 1'b0;
      skid_instr    <= dif.instr_reg_fetch;
      skid_pc       <= dif.pc_fetch;
      skid_npc      <= dif.npc_fetch;
    end
  end
`else
  assign dif.fetch_ready = dec_free;
  assign src_instr = dif.instr_reg_fetch;
  assign src_pc    = dif.pc_fetch;
  assign src_npc   = dif.npc_fetch;
  assign load      = accept;
`endif

  assign src_ctrl = decode_ctrl(src_instr[31:0]);

  decode_stage_imm_gen #(.data_width(data_width)) u_imm_gen (
    .instr (src_instr[31:0]),
    .imm   (src_imm)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_EMPTY;
      instr_q <= '0;
      pc_q    <= '0;
      npc_q   <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
    end else if (dif.flush) begin
      state <= ST_EMPTY;
    end else if (load) begin
      state   <= ST_FULL;
      instr_q <= src_instr;
      pc_q    <= src_pc;
      npc_q   <= src_npc;
      imm_q   <= src_imm;
      ctrl_q  <= src_ctrl;
    end else if (dif.ex_ready) begin
      state <= ST_EMPTY;
    end
  end

  assign dif.dec_valid   = (state == ST_FULL);
  assign dif.dec_instr   = instr_q;
  assign dif.dec_pc      = pc_q;
  assign dif.dec_npc     = npc_q;
  assign dif.dec_imm     = imm_q;
  assign dif.dec_rs1     = ctrl_q.rs1;
  assign dif.dec_rs2     = ctrl_q.rs2;
  assign dif.dec_rd      = ctrl_q.rd;
  assign dif.dec_opcode  = ctrl_q.opcode;
  assign dif.dec_funct3  = ctrl_q.funct3;
  assign dif.dec_funct7  = ctrl_q.funct7;
  assign dif.dec_rd_we   = ctrl_q.rd_we;
  assign dif.dec_illegal = ctrl_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: queue-based scoreboard of accepted fetch words
// plus a field-level RV32I decode model, with directed boundary cases.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.data_width(32)) dif();
  decode_stage #(.data_width(32)) dut (.clk(clk), .rst(rst), .dif(dif.slave));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr, pc, npc;
  } word_t;
  word_t q[$];

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        rd_we, illegal;
  } exp_t;

  bit          last_accept = 1'b0;
  bit          prev_fl     = 1'b0;
  logic [31:0] pc_ctr      = 32'h0000_1000;
  logic [6:0]  opcs [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                             7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RV32I field rules straight from the ISA tables.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic [6:0] op;
    bit legal;
    op = w[6:0];
    legal = op inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23,
                       7'h13, 7'h33, 7'h0f, 7'h73};
    e.opcode = op;
    e.rd = w[11:7];
    e.funct3 = w[14:12];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.funct7 = w[31:25];
    e.illegal = !legal;
    e.rd_we = legal && (w[11:7] != 0) && !(op inside {7'h63, 7'h23, 7'h0f});
    case (op)
      7'h37, 7'h17: e.imm = {w[31:12], 12'h000};
      7'h6f: e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      7'h67, 7'h03, 7'h13, 7'h0f, 7'h73: e.imm = 32'($signed(w[31:20]));
      7'h63: e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      7'h23: e.imm = 32'($signed({w[31:25], w[11:7]}));
      default: e.imm = 32'h0;
    endcase
    return e;
  endfunction

  // Compare process: samples mid-cycle, i.e. the values the next rising edge acts on.
  always @(negedge clk) begin
    exp_t e;
    last_accept = rst && dif.fetch_valid && dif.fetch_ready;
    if (!rst) begin
      q.delete();
      chk("rst_dec_valid", dif.dec_valid, 0);
      chk("rst_dec_instr", dif.dec_instr, 0);
      chk("rst_dec_imm", dif.dec_imm, 0);
      chk("rst_dec_ctrl", {dif.dec_rd, dif.dec_rs1, dif.dec_rd_we, dif.dec_illegal}, 0);
    end else begin
      chk("dec_valid", dif.dec_valid, q.size() != 0);
`ifdef DECODE_SKID_BUFFER_EN
      chk("fetch_ready", dif.fetch_ready, q.size() < 2);
`else
      chk("fetch_ready", dif.fetch_ready, (q.size() == 0) || dif.ex_ready);
`endif
      if (dif.dec_valid && q.size() != 0) begin
        e = model(q[0].instr);
        chk("dec_instr", dif.dec_instr, q[0].instr);
        chk("dec_pc", dif.dec_pc, q[0].pc);
        chk("dec_npc", dif.dec_npc, q[0].npc);
        chk("dec_imm", dif.dec_imm, e.imm);
        chk("dec_regs", {dif.dec_rd, dif.dec_rs1, dif.dec_rs2}, {e.rd, e.rs1, e.rs2});
        chk("dec_funct", {dif.dec_opcode, dif.dec_funct3, dif.dec_funct7},
            {e.opcode, e.funct3, e.funct7});
        chk("dec_rd_we", dif.dec_rd_we, e.rd_we);
        chk("dec_illegal", dif.dec_illegal, e.illegal);
      end
      if (dif.flush) q.delete();
      else begin
        if (dif.dec_valid && dif.ex_ready && q.size() != 0) void'(q.pop_front());
        if (dif.fetch_valid && dif.fetch_ready)
          q.push_back('{dif.instr_reg_fetch, dif.pc_fetch, dif.npc_fetch});
      end
    end
  end

  task automatic set_word(input logic [31:0] w);
    dif.instr_reg_fetch = w;
    dif.pc_fetch = pc_ctr;
    dif.npc_fetch = pc_ctr + 32'd4;
    pc_ctr = pc_ctr + 32'd4;
  endtask

  task automatic new_word();
    logic [31:0] r;
    int sel;
    r = $urandom();
    sel = $urandom_range(0, 9);
    if (sel == 0) set_word(r);
    else set_word({r[31:7], opcs[$urandom_range(0, 10)]});
  endtask

  // One cycle of fetch/execute behaviour; an unconsumed word is held until taken.
  task automatic step(input bit fv_en, input bit er, input bit fl);
    if (!dif.fetch_valid || last_accept || prev_fl) new_word();
    prev_fl = fl;
    dif.fetch_valid = fv_en;
    dif.ex_ready = er;
    dif.flush = fl;
    @(posedge clk); #2;
  endtask

  task automatic send_one(input logic [31:0] w);
    set_word(w);
    dif.fetch_valid = 1'b1;
    dif.ex_ready = 1'b1;
    dif.flush = 1'b0;
    @(posedge clk); #2;
    dif.fetch_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a_word;
    exp_t m;
    dif.instr_reg_fetch = '0;
    dif.pc_fetch = '0;
    dif.npc_fetch = '0;
    dif.fetch_valid = 1'b0;
    dif.ex_ready = 1'b0;
    dif.flush = 1'b0;

    m = model(32'h00500093); chk("model_addi_imm", m.imm, 32'd5);
    m = model(32'hFE20AE23); chk("model_sw_imm", m.imm, 32'hFFFF_FFFC);
    m = model(32'hFE000EE3); chk("model_beq_imm", m.imm, 32'hFFFF_FFFC);
    m = model(32'h123452B7); chk("model_lui_imm", m.imm, 32'h1234_5000);
    m = model(32'hFFFFFFFF); chk("model_ill", {m.illegal, m.rd_we}, 2'b10);

    repeat (3) @(posedge clk);
    #2;
    chk("reset_valid", dif.dec_valid, 0);
    chk("reset_instr", dif.dec_instr, 0);
    rst = 1'b1;
    #1 chk("reset_fetch_ready", dif.fetch_ready, 1);
    @(posedge clk); #2;

    send_one(32'h00500093);
    chk("addi_valid", dif.dec_valid, 1);
    chk("addi_rd", dif.dec_rd, 1);
    chk("addi_rs1", dif.dec_rs1, 0);
    chk("addi_imm", dif.dec_imm, 5);
    chk("addi_rd_we", dif.dec_rd_we, 1);
    send_one(32'hFE20AE23);
    chk("sw_imm", dif.dec_imm, 32'hFFFF_FFFC);
    chk("sw_rs1", dif.dec_rs1, 1);
    chk("sw_rs2", dif.dec_rs2, 2);
    chk("sw_rd_we", dif.dec_rd_we, 0);
    send_one(32'hFE000EE3);
    chk("beq_imm", dif.dec_imm, 32'hFFFF_FFFC);
    send_one(32'h123452B7);
    chk("lui_imm", dif.dec_imm, 32'h1234_5000);
    chk("lui_rd", dif.dec_rd, 5);
    send_one(32'hFFFFFFFF);
    chk("ill_flag", dif.dec_illegal, 1);
    chk("ill_rd_we", dif.dec_rd_we, 0);
    chk("ill_imm", dif.dec_imm, 0);
    send_one(32'h00500093);
    chk("after_ill_valid", dif.dec_valid, 1);
    chk("after_ill_instr", dif.dec_instr, 32'h00500093);

    // Execute stall with fetch still pushing.
    step(1, 1, 0);
    a_word = dif.instr_reg_fetch;
    chk("stall_first", dif.dec_instr, a_word);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      chk("stall_hold_instr", dif.dec_instr, a_word);
      chk("stall_hold_valid", dif.dec_valid, 1);
    end
    repeat (6) step(1, 1, 0);

    // Flush while full, once with execute consuming and once stalled.
    step(1, 0, 0);
    step(1, 1, 1);
    chk("flush_valid_a", dif.dec_valid, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    chk("flush_valid_b", dif.dec_valid, 0);
    repeat (4) step(1, 1, 0);

    // Reset during a stall.
    step(1, 0, 0);
    step(1, 0, 0);
    rst = 1'b0;
    #1;
    chk("midrst_valid", dif.dec_valid, 0);
    chk("midrst_instr", dif.dec_instr, 0);
    chk("midrst_imm", dif.dec_imm, 0);
    dif.fetch_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("midrst_fetch_ready", dif.fetch_ready, 1);
    @(posedge clk); #2;

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
    repeat (5) step(0, 1, 0);
    chk("drained", dif.dec_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
